// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for masters and slaves.
//   htrans_e : transfer type codes (IDLE, BUSY, NONSEQ, SEQ)
//   hburst_e : burst type codes
//   hsize_e  : transfer size codes (BYTE, HALF, WORD)
//   hresp_e  : response codes (OKAY, ERROR)
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

endpackage

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-transfer AHB-Lite master turning a valid/ready command stream into NONSEQ SINGLE transfers.
//   HCLK/HRESETn          : bus clock, async active-low reset
//   cmd_*                 : local command in (valid/ready, write, addr, size, wdata)
//   rsp_*                 : registered response pulse (rdata, err)
//   HADDR..HWDATA         : AHB-Lite master outputs, all from flops
//   HREADY/HRDATA/HRESP   : AHB-Lite slave-side inputs
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter int         ADDR_W    = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_size,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [31:0]       HWDATA,
    input  logic              HREADY,
    input  logic [31:0]       HRDATA,
    input  logic              HRESP
);

    logic              a_valid_q, a_valid_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic              a_write_q, a_write_d;
    logic [1:0]        a_size_q, a_size_d;
    logic [31:0]       a_wdata_q, a_wdata_d;
    logic              a_kill_q, a_kill_d;
    logic              d_valid_q, d_valid_d;
    logic              d_write_q, d_write_d;
    logic [31:0]       d_wdata_q, d_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              hs;
    logic              a_live;

    // No new command may enter while the bus stalls, a killed transfer waits
    // for its retry, or the current data phase is answering ERROR.
    assign cmd_ready = HREADY & ~a_kill_q & ~(d_valid_q & HRESP);
    assign hs        = cmd_valid & cmd_ready;
    assign a_live    = a_valid_q & ~a_kill_q;

    assign HADDR     = a_addr_q;
    assign HTRANS    = a_live ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWRITE    = a_write_q;
    assign HSIZE     = {1'b0, a_size_q};
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = d_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        a_valid_d   = a_valid_q;
        a_addr_d    = a_addr_q;
        a_write_d   = a_write_q;
        a_size_d    = a_size_q;
        a_wdata_d   = a_wdata_q;
        a_kill_d    = a_kill_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        d_wdata_d   = d_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        if (HREADY) begin
            rsp_valid_d = d_valid_q;
            rsp_err_d   = d_valid_q & HRESP;
            rsp_rdata_d = (d_valid_q & ~d_write_q & ~HRESP) ? HRDATA : '0;
            d_valid_d   = a_live;
            d_write_d   = a_live ? a_write_q : d_write_q;
            d_wdata_d   = a_live ? a_wdata_q : d_wdata_q;
            a_kill_d    = 1'b0;
            // A killed transfer keeps its address stage so it is re-driven next cycle.
            if (!a_kill_q) begin
                a_valid_d = hs;
                a_addr_d  = hs ? cmd_addr  : a_addr_q;
                a_write_d = hs ? cmd_write : a_write_q;
                a_size_d  = hs ? cmd_size  : a_size_q;
                a_wdata_d = hs ? cmd_wdata : a_wdata_q;
            end
        end else if (d_valid_q & HRESP) begin
            // First ERROR cycle: drop the pending address phase to IDLE for the second.
            a_kill_d = a_valid_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid_q   <= 1'b0;
            a_addr_q    <= '0;
            a_write_q   <= 1'b0;
            a_size_q    <= '0;
            a_wdata_q   <= '0;
            a_kill_q    <= 1'b0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_addr_q    <= a_addr_d;
            a_write_q   <= a_write_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            a_kill_q    <= a_kill_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_wdata_q   <= d_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed bench with a response scoreboard and a minimal AHB slave model.
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [1:0]  cmd_size = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA;
    logic        HRESP = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    ahb_lite_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Slave model: read data is {16'hC0DE, addr[15:0]} of the transfer in data phase.
    logic        dp_valid;
    logic        dp_write;
    logic [31:0] dp_addr;
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else if (HREADY) begin
            dp_valid <= (HTRANS == 2'b10);
            dp_write <= HWRITE;
            dp_addr  <= HADDR;
        end
    end
    assign HRDATA = (dp_valid && !dp_write) ? {16'hC0DE, dp_addr[15:0]} : 32'h0;

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got rdata=%h err=%b with no command outstanding", rsp_rdata, rsp_err);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL rsp got rdata=%h err=%b exp rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Present a command until accepted; on return the bench sits in the address-phase cycle.
    task automatic send(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input bit push);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cmd_ready) begin
                if (push) exp_q.push_back('{er, ee});
                tick();
                cmd_valid = 1'b0;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL send_timeout addr %h never accepted", a);
        cmd_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_htrans", {30'b0, HTRANS}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", {31'b0, HWRITE}, 32'h0);
        chk("rst_hsize", {29'b0, HSIZE}, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        HRESETn = 1'b1;
        tick();
        chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'h1);

        // Single write, zero wait states.
        send(1'b1, 32'h4000_0010, 2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
        chk("wr_htrans", {30'b0, HTRANS}, 32'h2);
        chk("wr_haddr", HADDR, 32'h4000_0010);
        chk("wr_hwrite", {31'b0, HWRITE}, 32'h1);
        chk("wr_hsize", {29'b0, HSIZE}, 32'h2);
        tick();
        chk("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
        chk("wr_htrans_idle", {30'b0, HTRANS}, 32'h0);
        chk("wr_rsp_early", {31'b0, rsp_valid}, 32'h0);
        tick();
        chk("wr_rsp_n3", {31'b0, rsp_valid}, 32'h1);
        tick();

        // Back-to-back reads.
        send(1'b0, 32'h10, 2'd2, 32'h0, 32'hC0DE_0010, 1'b0, 1'b1);
        chk("rd1_htrans", {30'b0, HTRANS}, 32'h2);
        chk("rd1_haddr", HADDR, 32'h10);
        send(1'b0, 32'h14, 2'd2, 32'h0, 32'hC0DE_0014, 1'b0, 1'b1);
        chk("rd2_htrans", {30'b0, HTRANS}, 32'h2);
        chk("rd2_haddr", HADDR, 32'h14);
        tick();
        chk("rd1_rsp", {31'b0, rsp_valid}, 32'h1);
        tick();
        chk("rd2_rsp", {31'b0, rsp_valid}, 32'h1);
        chk("rd2_rdata", rsp_rdata, 32'hC0DE_0014);
        tick();

        // Write with two wait states, next read queued in address phase.
        send(1'b1, 32'h100, 2'd2, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        send(1'b0, 32'h104, 2'd2, 32'h0, 32'hC0DE_0104, 1'b0, 1'b1);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) HREADY = 1'b1;
            #1;
            chk("ws_htrans", {30'b0, HTRANS}, 32'h2);
            chk("ws_haddr", HADDR, 32'h104);
            chk("ws_hwdata", HWDATA, 32'h1234_5678);
            chk("ws_rsp_valid", {31'b0, rsp_valid}, 32'h0);
            if (i < 2) chk("ws_cmd_ready", {31'b0, cmd_ready}, 32'h0);
            tick();
        end
        chk("ws_wr_rsp", {31'b0, rsp_valid}, 32'h1);
        tick();
        chk("ws_rd_rsp", {31'b0, rsp_valid}, 32'h1);
        chk("ws_rd_rdata", rsp_rdata, 32'hC0DE_0104);
        tick();

        // ERROR on read 0x20 while read 0x24 waits in address phase.
        send(1'b0, 32'h20, 2'd2, 32'h0, 32'h0, 1'b1, 1'b1);
        send(1'b0, 32'h24, 2'd2, 32'h0, 32'hC0DE_0024, 1'b0, 1'b1);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        #1;
        chk("err1_htrans", {30'b0, HTRANS}, 32'h2);
        chk("err1_haddr", HADDR, 32'h24);
        chk("err1_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        tick();
        HREADY = 1'b1;
        #1;
        chk("err2_htrans", {30'b0, HTRANS}, 32'h0);
        chk("err2_haddr", HADDR, 32'h24);
        chk("err2_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("err2_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        tick();
        HRESP = 1'b0;
        #1;
        chk("retry_htrans", {30'b0, HTRANS}, 32'h2);
        chk("retry_haddr", HADDR, 32'h24);
        chk("err_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("err_rsp_err", {31'b0, rsp_err}, 32'h1);
        chk("err_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        chk("retry_dphase_rsp", {31'b0, rsp_valid}, 32'h0);
        tick();
        chk("retry_rsp", {31'b0, rsp_valid}, 32'h1);
        chk("retry_rdata", rsp_rdata, 32'hC0DE_0024);
        tick();

        // Byte write: constant bus attributes.
        send(1'b1, 32'h0000_0003, 2'd0, 32'hAB00_0000, 32'h0, 1'b0, 1'b1);
        chk("b_haddr", HADDR, 32'h3);
        chk("b_hsize", {29'b0, HSIZE}, 32'h0);
        chk("b_hburst", {29'b0, HBURST}, 32'h0);
        chk("b_hprot", {28'b0, HPROT}, 32'h3);
        chk("b_hmastlock", {31'b0, HMASTLOCK}, 32'h0);
        tick();
        chk("b_hwdata", HWDATA, 32'hAB00_0000);
        tick();
        tick();

        // Reset during the data phase of a read: no response for it.
        send(1'b0, 32'h30, 2'd2, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        HRESETn = 1'b0;
        #1;
        chk("rst_mid_htrans", {30'b0, HTRANS}, 32'h0);
        chk("rst_mid_rsp", {31'b0, rsp_valid}, 32'h0);
        tick();
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        send(1'b0, 32'h40, 2'd2, 32'h0, 32'hC0DE_0040, 1'b0, 1'b1);
        chk("post_rst_htrans", {30'b0, HTRANS}, 32'h2);
        tick();
        tick();
        chk("post_rst_rsp", {31'b0, rsp_valid}, 32'h1);
        chk("post_rst_rdata", rsp_rdata, 32'hC0DE_0040);
        tick();
        tick();
        chk("pending_rsps", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-transfer AHB-Lite bus master: the initiator end of the bus that the team's AHB slaves (IO/register blocks) respond to.
- Converts a simple local command stream (valid/ready) into pipelined NONSEQ SINGLE transfers.
- Handles wait states and the two-cycle ERROR response.
- Returns read data and completion status on a registered response port.
- Sits between a local controller (test sequencer, DMA-lite, CPU shim) and the AHB-Lite interconnect.

Parameters:
- HPROT_VAL, 4'b0011, constant value driven on HPROT (non-cacheable, privileged data).
- ADDR_W, 32, width of cmd_addr / HADDR.

Ports:
- HCLK  in  1  bus clock; all logic is posedge HCLK.
- HRESETn  in  1  async active-low reset.
- cmd_valid  in  1  local command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address; must be aligned to cmd_size.
- cmd_size  in  2  HSIZE[1:0]: 0 = byte, 1 = half, 2 = word.
- cmd_wdata  in  32  write data, lane-placed by the requester.
- rsp_valid  out  1  one-cycle pulse per completed or cancelled transfer.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  transfer ended with ERROR.
- HADDR  out  ADDR_W  address phase.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1  address-phase write flag.
- HSIZE  out  3  {1'b0, size}.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  HPROT_VAL.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  data-phase write data.
- HREADY  in  1  bus ready (interconnect-muxed HREADYOUT).
- HRDATA  in  32  read data.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK.
- Two register stages:
  - address-phase stage A: a_valid, a_addr, a_write, a_size, a_wdata.
  - data-phase stage D: d_valid, d_write, d_wdata.
- Bus outputs come directly from flops:
  - HADDR, HWRITE, HSIZE from A.
  - HTRANS = NONSEQ when a_valid & !a_kill, else IDLE.
  - HWDATA = d_wdata.
- Reset values:
  - a_valid = 0, d_valid = 0, a_kill = 0.
  - HTRANS = IDLE; HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- cmd_ready = HREADY & !a_kill & !(d_valid & HRESP). This is combinational and there is no other backpressure.
- On a posedge with HREADY = 1:
  - If d_valid: the data phase completes. Next cycle rsp_valid = 1 and rsp_err = HRESP. rsp_rdata = HRDATA if the transfer was a read and HRESP = 0, else 0.
  - D <= A when a_valid & !a_kill; otherwise d_valid <= 0.
  - A <= cmd on handshake; otherwise a_valid <= 0. Exception: after a kill, A is retained (see error handling).
- On a posedge with HREADY = 0: A and D hold and no response is produced. HADDR/HTRANS must stay stable, as AHB requires.
- Throughput: back-to-back commands give one transfer per cycle with zero wait states. Latency from cmd handshake to rsp_valid is 3 cycles with zero wait states, plus the wait-state count.
- ERROR handling (two-cycle ERROR):
  - Cycle 1 is detected at a posedge where d_valid & HRESP & !HREADY. Set a_kill = 1 if a_valid, so HTRANS = IDLE during ERROR cycle 2 while HADDR holds.
  - At ERROR cycle 2 completion (HREADY = 1): report the error, keep A unchanged, clear a_kill. The pending transfer is re-driven NONSEQ the following cycle.
  - Net effect: the pending transfer is retried, not dropped, and responses stay in command order.
- An ERROR on a write produces rsp_err = 1 and rsp_rdata = 0.
- No responses are lost; rsp_valid fires exactly once per accepted command.
- Reset mid-transfer: all state clears immediately, and the in-flight command produces no response.
- HRESP = 1 with HREADY = 1 while d_valid = 0 (a protocol violation) is ignored.

Decomposition:
- Shared package ahb_pkg, also used by the slaves:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ).
  - HBURST codes.
  - HSIZE codes (BYTE, HALF, WORD).
  - HRESP codes (OKAY, ERROR).
- No sub-module. The two pipeline stages and the response register live in one module.

Test Plan:
- Single write 0x4000_0010 = 0xDEAD_BEEF, zero wait:
  - cycle n+1: HTRANS = 10, HADDR = 0x4000_0010, HWRITE = 1.
  - cycle n+2: HWDATA = 0xDEAD_BEEF.
  - rsp_valid at n+3 with rsp_err = 0.
- Read 0x10, then read 0x14 back-to-back:
  - two consecutive NONSEQ cycles.
  - rsp_rdata returns the slave values in order on consecutive cycles.
- Write with slave inserting 2 wait states (HREADY low 2 cycles): HADDR of the next queued command, HWDATA and HTRANS stay stable throughout; cmd_ready = 0 during the waits; rsp_valid is delayed by 2 cycles.
- Read 0x20 gets ERROR while read 0x24 is pending: HTRANS = IDLE in ERROR cycle 2; rsp for 0x20 has err = 1 and rdata = 0; 0x24 is then reissued NONSEQ and returns OKAY data.
- Byte write size = 0 to 0x0000_0003: HSIZE = 000 and HBURST = 000, HPROT = 0011, HMASTLOCK = 0 on the bus.
- Assert HRESETn low during the data phase of a read: HTRANS = IDLE and rsp_valid = 0 immediately; after release, a fresh command completes normally.
